// File: rtl/filter_output_capture.sv
`default_nettype none
// ============================================================================
// Module      : filter_output_capture
// Description : Capture sink for a 3-lane parallel FIR. Each valid beat stores
//               its three samples into an internal RAM in sample order
//               (lane 1 at n, lane 2 at n+1, lane 3 at n+2). The captured
//               words are read back one per cycle with one clock of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module filter_output_capture #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data_1,
    input  logic [DATA_WIDTH-1:0] in_data_2,
    input  logic [DATA_WIDTH-1:0] in_data_3,
    output logic                  capturing,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   wr_count,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    // A beat that leaves the count above this value leaves no room for
    // another whole beat, so capture ends rather than writing a partial one.
    localparam logic [ADDR_WIDTH:0] c_full_limit = (ADDR_WIDTH + 1)'(c_depth - 3);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_capture = 2'd1;
    localparam logic [1:0] c_st_done    = 2'd2;

    logic [1:0]            r_state;
    logic [ADDR_WIDTH:0]   r_wr_count;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_mem [c_depth];

    logic                  w_wr_en;
    logic [ADDR_WIDTH:0]   w_next_count;
    logic [ADDR_WIDTH-1:0] w_addr0;
    logic [ADDR_WIDTH-1:0] w_addr1;
    logic [ADDR_WIDTH-1:0] w_addr2;

    // While writing, the count is at most DEPTH-3, so the three lane addresses
    // never wrap and the low ADDR_WIDTH bits are the full address.
    assign w_addr0      = r_wr_count[ADDR_WIDTH-1:0];
    assign w_addr1      = w_addr0 + ADDR_WIDTH'(1);
    assign w_addr2      = w_addr0 + ADDR_WIDTH'(2);
    assign w_next_count = r_wr_count + (ADDR_WIDTH + 1)'(3);

    // A beat coinciding with reset must not reach the RAM.
    assign w_wr_en = (r_state == c_st_capture) && in_valid && !rst;

    // Capture control: state, word counter and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_wr_count <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state    <= c_st_capture;
                        r_wr_count <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                c_st_capture: begin
                    // start is ignored here; a beat with stop is still written.
                    if (in_valid) begin
                        r_wr_count <= w_next_count;
                        if (stop || (w_next_count > c_full_limit)) begin
                            r_state <= c_st_done;
                        end
                    end else if (stop) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (start) begin
                        r_state    <= c_st_capture;
                        r_wr_count <= '0;
                        r_overflow <= 1'b0;
                    end else if (in_valid) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Three-word RAM write for each accepted beat; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_addr0] <= in_data_1;
            r_mem[w_addr1] <= in_data_2;
            r_mem[w_addr2] <= in_data_3;
        end
    end

    // Registered readback; read-first, so a same-cycle write returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign capturing = (r_state == c_st_capture);
    assign done      = (r_state == c_st_done);
    assign overflow  = r_overflow;
    assign wr_count  = r_wr_count;
    assign rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_filter_output_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_output_capture
// Description : Directed self-checking bench for filter_output_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_output_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data_1 = '0;
    logic [15:0] in_data_2 = '0;
    logic [15:0] in_data_3 = '0;
    logic        capturing;
    logic        done;
    logic        overflow;
    logic [9:0]  wr_count;
    logic [8:0]  rd_addr = '0;
    logic [15:0] rd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    filter_output_capture #(.ADDR_WIDTH(9), .DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .in_data_3 (in_data_3),
        .capturing (capturing),
        .done      (done),
        .overflow  (overflow),
        .wr_count  (wr_count),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        in_valid  = 1'b1;
        in_data_1 = a;
        in_data_2 = b;
        in_data_3 = c;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++; if (capturing !== 1'b0) begin bad++; $display("FAIL reset_capturing got=%b exp=0", capturing); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (wr_count !== 10'd0) begin bad++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        total++; if (rd_data !== 16'd0) begin bad++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        pulse_start();
        total++; if (capturing !== 1'b1) begin bad++; $display("FAIL basic_capturing got=%b exp=1", capturing); end
        beat(16'd1, 16'd2, 16'd3);
        beat(16'd4, 16'd5, 16'd6);
        beat(16'd7, 16'd8, 16'd9);
        beat(16'd10, 16'd11, 16'd12);
        total++; if (wr_count !== 10'd12) begin bad++; $display("FAIL basic_count got=%0d exp=12", wr_count); end
        pulse_stop();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b exp=1", done); end
        total++; if (capturing !== 1'b0) begin bad++; $display("FAIL basic_cap_off got=%b exp=0", capturing); end
        total++; if (wr_count !== 10'd12) begin bad++; $display("FAIL basic_count_hold got=%0d exp=12", wr_count); end
        for (int i = 0; i < 12; i++) begin
            rd_addr = 9'(i);
            tick();
            total++;
            if (rd_data !== 16'(i + 1)) begin
                bad++; $display("FAIL basic_read addr=%0d got=%0d exp=%0d", i, rd_data, i + 1);
            end
        end
    endtask

    task automatic test_full();
        pulse_start();
        for (int k = 0; k < 170; k++) begin
            beat(16'(3 * k), 16'(3 * k + 1), 16'(3 * k + 2));
            if (k == 168) begin
                total++; if (capturing !== 1'b1 || wr_count !== 10'd507) begin
                    bad++; $display("FAIL full_pre cap=%b count=%0d exp cap=1 count=507", capturing, wr_count);
                end
            end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%b exp=1", done); end
        total++; if (capturing !== 1'b0) begin bad++; $display("FAIL full_cap_off got=%b exp=0", capturing); end
        total++; if (wr_count !== 10'd510) begin bad++; $display("FAIL full_count got=%0d exp=510", wr_count); end
        rd_addr = 9'd509;
        tick();
        total++; if (rd_data !== 16'd509) begin bad++; $display("FAIL full_read509 got=%0d exp=509", rd_data); end
        rd_addr = 9'd255;
        tick();
        total++; if (rd_data !== 16'd255) begin bad++; $display("FAIL full_read255 got=%0d exp=255", rd_data); end
    endtask

    task automatic test_overflow();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        beat(16'd1, 16'd1, 16'd1);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        total++; if (wr_count !== 10'd510) begin bad++; $display("FAIL ovf_count got=%0d exp=510", wr_count); end
        tick();
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        pulse_start();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_restart got=%b exp=0", overflow); end
        total++; if (wr_count !== 10'd0) begin bad++; $display("FAIL ovf_restart_count got=%0d exp=0", wr_count); end
        total++; if (capturing !== 1'b1) begin bad++; $display("FAIL ovf_restart_cap got=%b exp=1", capturing); end
        pulse_stop();
    endtask

    task automatic test_start_valid();
        start     = 1'b1;
        in_valid  = 1'b1;
        in_data_1 = 16'd9;
        in_data_2 = 16'd9;
        in_data_3 = 16'd9;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        total++; if (wr_count !== 10'd0) begin bad++; $display("FAIL sv_count got=%0d exp=0", wr_count); end
        total++; if (capturing !== 1'b1) begin bad++; $display("FAIL sv_cap got=%b exp=1", capturing); end
        beat(16'd1, 16'd2, 16'd3);
        total++; if (wr_count !== 10'd3) begin bad++; $display("FAIL sv_count2 got=%0d exp=3", wr_count); end
        for (int i = 0; i < 3; i++) begin
            rd_addr = 9'(i);
            tick();
            total++;
            if (rd_data !== 16'(i + 1)) begin
                bad++; $display("FAIL sv_read addr=%0d got=%0d exp=%0d", i, rd_data, i + 1);
            end
        end
        pulse_stop();
    endtask

    task automatic test_rst_mid();
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            beat(16'(100 + 3 * k), 16'(101 + 3 * k), 16'(102 + 3 * k));
        end
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data_1 = 16'd7;
        in_data_2 = 16'd7;
        in_data_3 = 16'd7;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        total++; if (wr_count !== 10'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", wr_count); end
        total++; if (capturing !== 1'b0) begin bad++; $display("FAIL rst_cap got=%b exp=0", capturing); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        // Words 15..17 still hold the values from the full-depth run.
        for (int i = 0; i < 18; i++) begin
            rd_addr = 9'(i);
            tick();
            total++;
            if (rd_data !== ((i < 15) ? 16'(100 + i) : 16'(i))) begin
                bad++; $display("FAIL rst_read addr=%0d got=%0d exp=%0d", i, rd_data, (i < 15) ? 100 + i : i);
            end
        end
    endtask

    task automatic test_read_first();
        pulse_start();
        rd_addr = 9'd1;
        beat(16'hAAAA, 16'hBBBB, 16'hCCCC);
        total++; if (rd_data !== 16'd101) begin bad++; $display("FAIL rf_old got=%h exp=%h", rd_data, 16'd101); end
        tick();
        total++; if (rd_data !== 16'hBBBB) begin bad++; $display("FAIL rf_new got=%h exp=bbbb", rd_data); end
        // A beat with stop is still written before capture ends.
        stop = 1'b1;
        beat(16'd21, 16'd22, 16'd23);
        stop = 1'b0;
        total++; if (wr_count !== 10'd6 || done !== 1'b1) begin
            bad++; $display("FAIL stop_beat count=%0d done=%b exp count=6 done=1", wr_count, done);
        end
        rd_addr = 9'd5;
        tick();
        total++; if (rd_data !== 16'd23) begin bad++; $display("FAIL stop_read got=%0d exp=23", rd_data); end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_full();
        test_overflow();
        test_start_valid();
        test_rst_mid();
        test_read_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
